// File: rtl/seq101_pkg.sv
// Shared types and constants for the serial "101" link: transmitter FSM states
// and the bit pattern the downstream detector looks for.
package seq101_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;

  // Oldest bit first: {t-2, t-1, t}
  localparam logic [2:0] SEQ_PATTERN = 3'b101;

endpackage

// File: rtl/seq101_line_monitor.sv
// Watches a serial line and predicts the Mealy "101" detector output, counting
// predicted matches in a saturating counter. Usable on either end of the link.
module seq101_line_monitor
  import seq101_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  output logic             exp_y,
  output logic [CNT_W-1:0] match_cnt
);

  logic [1:0] hist;  // {bit at t-2, bit at t-1}

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 2'b00;
    else     hist <= {hist[0], data};
  end

  // Mealy prediction on the current bit; overlapping matches fall out naturally
  assign exp_y = (data == SEQ_PATTERN[0]) && (hist == SEQ_PATTERN[2:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           match_cnt <= '0;
    else if (exp_y && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
  end

endmodule

// File: rtl/seq101_serial_tx.sv
// Parallel-to-serial transmitter feeding the 101 detector, MSB first, with an
// optional forced idle gap after each word and a built-in line monitor.
module seq101_serial_tx
  import seq101_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_word,
  output logic             in_ready,
  output logic             data,
  output logic             tx_active,
  output logic             word_done,
  output logic             exp_y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tx_state_t        state, state_nx;
  logic [WIDTH-1:0] shift, shift_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic [GW-1:0]    gap_cnt, gap_cnt_nx;
  logic             tx_active_nx, word_done_nx;
  logic             last_bit, gap_last, xfer;

  assign last_bit = (state == SHIFT) && (bit_cnt == BW'(WIDTH - 1));
  assign gap_last = (int'(gap_cnt) == GAP_CYCLES - 1);
  assign xfer     = in_valid && in_ready;

  // The shift register is zero outside SHIFT, so its MSB is the line directly
  assign data = shift[WIDTH-1];

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      SHIFT:   in_ready = (GAP_CYCLES == 0) && last_bit;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nx   = SHIFT;
          shift_nx   = in_word;
          bit_cnt_nx = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (xfer) begin
            state_nx   = SHIFT;
            shift_nx   = in_word;
            bit_cnt_nx = '0;
          end else if (GAP_CYCLES > 0) begin
            state_nx   = GAP;
            shift_nx   = '0;
            gap_cnt_nx = '0;
          end else begin
            state_nx = IDLE;
            shift_nx = '0;
          end
        end else begin
          shift_nx   = {shift[WIDTH-2:0], 1'b0};
          bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) state_nx   = IDLE;
        else          gap_cnt_nx = gap_cnt + 1'b1;
      end
      default: begin
        state_nx = IDLE;
        shift_nx = '0;
      end
    endcase
  end

  // Status flags are registered from the next-state view so they line up with 'data'
  assign tx_active_nx = (state_nx == SHIFT);
  assign word_done_nx = (state_nx == SHIFT) && (bit_cnt_nx == BW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_active <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      bit_cnt   <= bit_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      tx_active <= tx_active_nx;
      word_done <= word_done_nx;
    end
  end

  seq101_line_monitor #(.CNT_W(CNT_W)) u_mon (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .exp_y     (exp_y),
    .match_cnt (match_cnt)
  );

endmodule
